// File: rtl/fabric_pkg.sv
// fabric_pkg: shared address map, default bank size, FSM encoding and address decode for fabric_mem_resp
package fabric_pkg;
  localparam logic [31:0] ADDR_MAP = 32'h4000_0000;
  localparam logic [31:0] ADDR_DIR = 32'h4000_2000;
  localparam int BANK_WORDS = 128;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_MAP, SEL_DIR} sel_t;
  // Each bank occupies a 512-byte window, so only addr[31:9] selects it.
  function automatic sel_t decode(input logic [22:0] page);
    return page == ADDR_MAP[31:9] ? SEL_MAP : page == ADDR_DIR[31:9] ? SEL_DIR : SEL_NONE;
  endfunction
endpackage

// File: rtl/fabric_mem_bank.sv
// fabric_mem_bank: WORDS x 32 storage with a txn port and a host port; txn write wins on same-word collision
// Ports: clk; t_we/t_idx/t_wdata/t_rdata txn side; h_we/h_idx/h_wdata/h_rdata host side.
// Reads are combinational, so a read in the write cycle returns the old word.
module fabric_mem_bank #(
  parameter int WORDS = 128,
  localparam int IW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          t_we,
  input  logic [IW-1:0] t_idx,
  input  logic [31:0]   t_wdata,
  output logic [31:0]   t_rdata,
  input  logic          h_we,
  input  logic [IW-1:0] h_idx,
  input  logic [31:0]   h_wdata,
  output logic [31:0]   h_rdata
);
  logic [31:0] mem [WORDS];
  assign t_rdata = mem[t_idx];
  assign h_rdata = mem[h_idx];
  always_ff @(posedge clk) begin
    if (h_we && !(t_we && h_idx == t_idx)) mem[h_idx] <= h_wdata;
    if (t_we) mem[t_idx] <= t_wdata;
  end
endmodule

// File: rtl/fabric_mem_resp.sv
// fabric_mem_resp: memory responder with map/dir banks, fixed-latency txn port and a host access port
// Ports: clk, arst_n (async active-low); txn_req/txn_wr/txn_addr/txn_wdata request;
//        txn_rdy/txn_rdata/txn_err completion; host_en/host_wr/host_addr/host_wdata/host_rdata host port;
//        ovr sticky dropped-request flag.
// Macro FABRIC_MEM_ERR_EN: when defined, txn_err flags unmapped addresses with txn_rdy.
module fabric_mem_resp
  import fabric_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int BANK_WORDS = fabric_pkg::BANK_WORDS
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        txn_req,
  input  logic        txn_wr,
  input  logic [31:0] txn_addr,
  input  logic [31:0] txn_wdata,
  output logic        txn_rdy,
  output logic [31:0] txn_rdata,
  output logic        txn_err,
  input  logic        host_en,
  input  logic        host_wr,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        ovr
);
  localparam int IW = $clog2(BANK_WORDS);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, ovr_q, ovr_d, accept, rsp;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, host_rdata_q, host_rdata_d, h_rd;
  logic [31:0] map_t_rdata, dir_t_rdata, map_h_rdata, dir_h_rdata;
  sel_t t_sel, h_sel;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[1:0], host_addr[1:0]};
  always_comb begin
    // A new request is taken in IDLE and in RESP (back-to-back); in WAIT it is dropped.
    accept = txn_req && state_q != ST_WAIT;
    rsp = state_q == ST_RESP;
    t_sel = decode(addr_q[31:9]);
    h_sel = decode(host_addr[31:9]);
    state_d = accept ? (WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT)
            : state_q == ST_WAIT ? (cnt_q == 4'(WAIT_CYCLES - 1) ? ST_RESP : ST_WAIT) : ST_IDLE;
    cnt_d = state_q == ST_WAIT ? cnt_q + 4'd1 : 4'd0;
    wr_d = accept ? txn_wr : wr_q;
    addr_d = accept ? txn_addr : addr_q;
    wdata_d = accept ? txn_wdata : wdata_q;
    ovr_d = ovr_q | (txn_req && state_q == ST_WAIT);
    h_rd = h_sel == SEL_MAP ? map_h_rdata : h_sel == SEL_DIR ? dir_h_rdata : 32'd0;
    host_rdata_d = host_en && !host_wr ? h_rd : host_rdata_q;
    txn_rdy = rsp;
    txn_rdata = rsp && !wr_q ? (t_sel == SEL_MAP ? map_t_rdata : t_sel == SEL_DIR ? dir_t_rdata : 32'd0) : 32'd0;
`ifdef FABRIC_MEM_ERR_EN
    txn_err = rsp && t_sel == SEL_NONE;
`else
    txn_err = 1'b0;
`endif
  end
  assign host_rdata = host_rdata_q;
  assign ovr = ovr_q;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ovr_q <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ovr_q <= ovr_d;
      host_rdata_q <= host_rdata_d;
    end
  fabric_mem_bank #(.WORDS(BANK_WORDS)) u_map (
    .clk(clk),
    .t_we(rsp && wr_q && t_sel == SEL_MAP), .t_idx(addr_q[2 +: IW]), .t_wdata(wdata_q), .t_rdata(map_t_rdata),
    .h_we(host_en && host_wr && h_sel == SEL_MAP), .h_idx(host_addr[2 +: IW]), .h_wdata(host_wdata), .h_rdata(map_h_rdata)
  );
  fabric_mem_bank #(.WORDS(BANK_WORDS)) u_dir (
    .clk(clk),
    .t_we(rsp && wr_q && t_sel == SEL_DIR), .t_idx(addr_q[2 +: IW]), .t_wdata(wdata_q), .t_rdata(dir_t_rdata),
    .h_we(host_en && host_wr && h_sel == SEL_DIR), .h_idx(host_addr[2 +: IW]), .h_wdata(host_wdata), .h_rdata(dir_h_rdata)
  );
endmodule

// File: doc/fabric_mem_resp.md
FABRIC_MEM_RESP -- requirements
Module: fabric_mem_resp

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra wait states between request capture and txn_rdy (range 0..15).
REQ-002 SHALL have parameter BANK_WORDS, default 128: words per bank (map bank, dir bank).
REQ-003 SHALL have port clk  in  1: single clock, all logic on rising edge.
REQ-004 SHALL have port arst_n  in  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports txn_req in 1, txn_wr in 1, txn_addr in 32, txn_wdata in 32: initiator request (one-cycle pulse, write flag, byte address, write data).
REQ-006 SHALL have ports txn_rdy out 1, txn_rdata out 32: completion pulse, read data valid while txn_rdy=1.
REQ-007 SHALL have port txn_err out 1: unmapped-address flag, valid with txn_rdy.
REQ-008 SHALL have ports host_en in 1, host_wr in 1, host_addr in 32, host_wdata in 32, host_rdata out 32: CPU-side access to both banks.
REQ-009 SHALL have port ovr out 1: sticky flag, request dropped while busy.

Function
REQ-010 SHALL decode map bank at 0x40000000..0x400001FF, dir bank at 0x40002000..0x400021FF; word index = addr[8:2]; addr[1:0] ignored; anything else unmapped.
REQ-011 SHALL run FSM IDLE -> WAIT -> RESP -> IDLE; IDLE->WAIT on txn_req (IDLE->RESP when WAIT_CYCLES=0); WAIT->RESP when wait counter reaches WAIT_CYCLES-1; RESP->IDLE, or RESP->WAIT/RESP if txn_req present that cycle.
REQ-012 SHALL capture txn_wr, txn_addr, txn_wdata in the request cycle; later changes to inputs SHALL not affect the transaction.
REQ-013 SHALL assert txn_rdy for exactly one cycle in RESP; latency request-cycle N -> txn_rdy at N+1+WAIT_CYCLES.
REQ-014 SHALL accept a new txn_req in the same cycle txn_rdy=1 (back-to-back) with no bubble beyond REQ-013 latency.
REQ-015 SHALL ignore txn_req in WAIT, set ovr=1 until reset, leave in-flight transaction unaffected.
REQ-016 SHALL perform writes to the bank in the RESP cycle; txn_rdata SHALL be 0 for writes.
REQ-017 SHALL return read data of the bank word as stored at the RESP cycle, including a same-cycle host write's old value (read-before-write).
REQ-018 SHALL give unmapped reads txn_rdata=0, drop unmapped writes, still complete with txn_rdy.
REQ-019 SHALL service host port every cycle: host_rdata registered, 1-cycle latency; unmapped host reads return 0.
REQ-020 SHALL, on simultaneous host write and txn write to the same word, keep the txn value.
REQ-021 SHALL hold txn_rdata and txn_err at 0 when txn_rdy=0.

Reset
REQ-022 SHALL on arst_n=0 force FSM IDLE, txn_rdy=0, txn_rdata=0, txn_err=0, ovr=0, host_rdata=0, wait counter 0.
REQ-023 SHALL abandon an in-flight transaction on reset mid-operation (no txn_rdy, write not performed if RESP not reached); bank contents SHALL not be reset.

Configuration
REQ-024 SHALL honour macro FABRIC_MEM_ERR_EN: defined -> txn_err=1 with txn_rdy for unmapped addresses; undefined -> txn_err tied 0, unmapped behaviour otherwise per REQ-018.

Structure
REQ-025 SHALL take ADDR_MAP, ADDR_DIR, BANK_WORDS default and FSM state encoding from shared package fabric_pkg.
REQ-026 SHALL instantiate sub-module fabric_mem_bank (BANK_WORDS x 32, one txn port, one host port, txn-priority write) twice.

Verification
REQ-027 SHALL cover: host write 0x12345678 to 0x40000004, txn read 0x40000004 at cycle 10 -> txn_rdy at cycle 12, txn_rdata=0x12345678.
REQ-028 SHALL cover: txn write 0xA5A5A5A5 to 0x40002010, wdata changed next cycle -> host read 0x40002010 returns 0xA5A5A5A5.
REQ-029 SHALL cover: 16 back-to-back reads, each issued in txn_rdy cycle, WAIT_CYCLES=0 -> txn_rdy every cycle, ovr=0.
REQ-030 SHALL cover: txn_req in WAIT state -> request dropped, ovr=1, original txn_rdy on time.
REQ-031 SHALL cover: read 0x50000000 with FABRIC_MEM_ERR_EN -> txn_rdy=1, txn_err=1, txn_rdata=0; without macro txn_err=0.
REQ-032 SHALL cover: arst_n low during WAIT of write to 0x40000008 -> no txn_rdy, word unchanged, outputs 0.
